// File: rtl/wb_regfile_pkg.sv
// Shared CPU types and constants for the writeback stage, the pipeline registers
// and the forwarding unit.
package wb_regfile_pkg;

    localparam int unsigned XLEN       = 32;
    localparam int unsigned NREG       = 32;
    localparam int unsigned REG_ADDR_W = 5;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;
    typedef logic [XLEN-1:0]       word_t;

    localparam reg_addr_t REG_ZERO = 5'd0;

    // A writeback retires only when enabled, aimed at a real register, and not
    // squashed by a same-cycle reset.
    function automatic logic wb_commit(input logic we, input reg_addr_t rd, input logic rst);
        return we && (rd != REG_ZERO) && !rst;
    endfunction

endpackage

// File: rtl/wb_regfile_if.sv
// MEM/WB -> register file bus: writeback payload, ID read ports, debug port and
// retired-write counter. master = pipeline/ID side, slave = register file.
interface wb_regfile_if #(
    parameter int unsigned CNT_W = 32
) ();
    import wb_regfile_pkg::*;

    // Writeback payload from the MEM/WB register
    logic       MemtoReg_wb;
    logic       RegWrite_wb;
    word_t      MemDout_wb;
    word_t      ALUResult_wb;
    reg_addr_t  rdAddr_wb;

    // ID read ports
    reg_addr_t  rs1Addr;
    reg_addr_t  rs2Addr;
    word_t      rs1Data;
    word_t      rs2Data;

    // Forwarding / status / debug
    word_t      wbData;
    logic       wbCommit;
    reg_addr_t  dbgAddr;
    word_t      dbgData;
    logic [CNT_W-1:0] wrCount;

    modport master (
        output MemtoReg_wb, RegWrite_wb, MemDout_wb, ALUResult_wb, rdAddr_wb,
        output rs1Addr, rs2Addr, dbgAddr,
        input  rs1Data, rs2Data, wbData, wbCommit, dbgData, wrCount
    );

    modport slave (
        input  MemtoReg_wb, RegWrite_wb, MemDout_wb, ALUResult_wb, rdAddr_wb,
        input  rs1Addr, rs2Addr, dbgAddr,
        output rs1Data, rs2Data, wbData, wbCommit, dbgData, wrCount
    );

endinterface

// File: rtl/wb_regfile_wb_mux.sv
// Final writeback select: load data vs ALU result. Reusable by the forwarding unit.
// Built as an AND-OR so an unknown load value cannot leak through when the ALU
// result is selected.
module wb_regfile_wb_mux
    import wb_regfile_pkg::*;
(
    input  logic  i_mem_to_reg,
    input  word_t i_mem_dout,
    input  word_t i_alu_result,
    output word_t o_wb_data
);

    // Select the value to be written back
    always_comb begin
        o_wb_data = ({XLEN{i_mem_to_reg}}  & i_mem_dout) |
                    ({XLEN{!i_mem_to_reg}} & i_alu_result);
    end

endmodule

// File: rtl/wb_regfile.sv
// Writeback stage and 32x32 architectural register file.
// Two combinational read ports for ID, a registered debug read port, a commit
// strobe and a retired-write counter. x0 is hardwired to zero.
// Optional macro WB_BYPASS_EN: write-through bypass of a same-cycle commit onto
// the ID read ports. Without it ID always sees the pre-edge stored value.
module wb_regfile
    import wb_regfile_pkg::*;
#(
    parameter int unsigned CNT_W = 32
) (
    input logic          clk,
    input logic          rst,
    wb_regfile_if.slave  bus
);

    word_t            r_regs [NREG];
    word_t            r_dbg_data;
    logic             r_wb_commit;
    logic [CNT_W-1:0] r_wr_count;

    word_t            w_wb_data;
    logic             w_commit;
    word_t            w_rs1_data;
    word_t            w_rs2_data;
    word_t            w_dbg_rd;

    wb_regfile_wb_mux u_wb_mux (
        .i_mem_to_reg (bus.MemtoReg_wb),
        .i_mem_dout   (bus.MemDout_wb),
        .i_alu_result (bus.ALUResult_wb),
        .o_wb_data    (w_wb_data)
    );

    // Commit qualifier shared by the array write, counter and strobe
    always_comb begin
        w_commit = wb_commit(bus.RegWrite_wb, bus.rdAddr_wb, rst);
    end

    // Register array; entry 0 is reset and never written, so it stays zero
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_commit) begin
            r_regs[bus.rdAddr_wb] <= w_wb_data;
        end
    end

    // ID read ports; commit implies rd != x0, so the bypass never touches x0
    always_comb begin
        w_rs1_data = (bus.rs1Addr == REG_ZERO) ? '0 : r_regs[bus.rs1Addr];
        w_rs2_data = (bus.rs2Addr == REG_ZERO) ? '0 : r_regs[bus.rs2Addr];
`ifdef WB_BYPASS_EN
        if (w_commit && (bus.rs1Addr == bus.rdAddr_wb)) begin
            w_rs1_data = w_wb_data;
        end
        if (w_commit && (bus.rs2Addr == bus.rdAddr_wb)) begin
            w_rs2_data = w_wb_data;
        end
`endif
    end

    // Debug read source: stored value only, never bypassed
    always_comb begin
        w_dbg_rd = (bus.dbgAddr == REG_ZERO) ? '0 : r_regs[bus.dbgAddr];
    end

    // Debug register, commit strobe and retired-write counter (wraps naturally)
    always_ff @(posedge clk) begin
        if (rst) begin
            r_dbg_data  <= '0;
            r_wb_commit <= 1'b0;
            r_wr_count  <= '0;
        end else begin
            r_dbg_data  <= w_dbg_rd;
            r_wb_commit <= w_commit;
            if (w_commit) begin
                r_wr_count <= r_wr_count + CNT_W'(1);
            end
        end
    end

    // Drive the bus outputs
    always_comb begin
        bus.wbData   = w_wb_data;
        bus.rs1Data  = w_rs1_data;
        bus.rs2Data  = w_rs2_data;
        bus.dbgData  = r_dbg_data;
        bus.wbCommit = r_wb_commit;
        bus.wrCount  = r_wr_count;
    end

endmodule

// File: tb/tb_wb_regfile.sv
// Self-checking bench for wb_regfile: directed steps followed by random traffic,
// checked against an array-based model of the architectural register file.
// A second instance with a 4-bit counter exercises counter wrap.
module tb_wb_regfile;

    logic clk;
    logic rst;

    wb_regfile_if #(.CNT_W(32)) bus ();
    wb_regfile_if #(.CNT_W(4))  bus4 ();

    wb_regfile #(.CNT_W(32)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    wb_regfile #(.CNT_W(4)) u_dut_w4 (
        .clk (clk),
        .rst (rst),
        .bus (bus4)
    );

    assign bus4.MemtoReg_wb  = bus.MemtoReg_wb;
    assign bus4.RegWrite_wb  = bus.RegWrite_wb;
    assign bus4.MemDout_wb   = bus.MemDout_wb;
    assign bus4.ALUResult_wb = bus.ALUResult_wb;
    assign bus4.rdAddr_wb    = bus.rdAddr_wb;
    assign bus4.rs1Addr      = bus.rs1Addr;
    assign bus4.rs2Addr      = bus.rs2Addr;
    assign bus4.dbgAddr      = bus.dbgAddr;

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef WB_BYPASS_EN
    bit m_bypass = 1'b1;
`else
    bit m_bypass = 1'b0;
`endif

    // Reference model state
    logic [31:0] m_regs [32];
    longint      m_cnt;
    logic        m_commit;
    logic [31:0] m_dbg;

    int vectors;
    int miscompares;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model_read(input logic [4:0] a, input logic commit,
                                               input logic [4:0] rd, input logic [31:0] wb);
        if (a == 5'd0) return 32'd0;
        if (m_bypass && commit && a == rd) return wb;
        return m_regs[a];
    endfunction

    // One clock cycle: drive inputs, check combinational outputs before the edge,
    // advance the model, check registered outputs after the edge.
    task automatic cyc(input logic r, input logic we, input logic mts,
                       input logic [31:0] mem, input logic [31:0] alu,
                       input logic [4:0] rd, input logic [4:0] a1, input logic [4:0] a2,
                       input logic [4:0] ad);
        logic [31:0] exp_wb;
        logic        commit;
        rst              = r;
        bus.RegWrite_wb  = we;
        bus.MemtoReg_wb  = mts;
        bus.MemDout_wb   = mem;
        bus.ALUResult_wb = alu;
        bus.rdAddr_wb    = rd;
        bus.rs1Addr      = a1;
        bus.rs2Addr      = a2;
        bus.dbgAddr      = ad;
        #4;
        exp_wb = (mts === 1'b1) ? mem : alu;
        commit = we && (rd != 5'd0) && !r;
        chk("wbData", bus.wbData, exp_wb);
        chk("rs1Data", bus.rs1Data, model_read(a1, commit, rd, exp_wb));
        chk("rs2Data", bus.rs2Data, model_read(a2, commit, rd, exp_wb));
        if (r) begin
            foreach (m_regs[i]) m_regs[i] = 32'd0;
            m_cnt    = 0;
            m_commit = 1'b0;
            m_dbg    = 32'd0;
        end else begin
            m_dbg    = m_regs[ad];
            m_commit = commit;
            if (commit) begin
                m_regs[rd] = exp_wb;
                m_cnt++;
            end
        end
        @(posedge clk);
        #1;
        chk("wbCommit", 32'(bus.wbCommit), 32'(m_commit));
        chk("dbgData", bus.dbgData, m_dbg);
        chk("wrCount", bus.wrCount, 32'(m_cnt & 64'hFFFF_FFFF));
        chk("wrCount4", 32'(bus4.wrCount), 32'(m_cnt & 64'hF));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] xval;
        logic [4:0]  rd, a1, a2, ad;
        vectors     = 0;
        miscompares = 0;
        xval        = 'x;
        foreach (m_regs[i]) m_regs[i] = 32'hDEAD_0000;
        m_cnt    = 0;
        m_commit = 1'b0;
        m_dbg    = 32'd0;

        rst              = 1'b1;
        bus.RegWrite_wb  = 1'b0;
        bus.MemtoReg_wb  = 1'b0;
        bus.MemDout_wb   = 32'd0;
        bus.ALUResult_wb = 32'd0;
        bus.rdAddr_wb    = 5'd0;
        bus.rs1Addr      = 5'd0;
        bus.rs2Addr      = 5'd0;
        bus.dbgAddr      = 5'd0;
        @(posedge clk);
        #1;

        // Reset, then reset-state reads
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 5'd3, 5'd31, 5'd17);

        // Write/readback through both select paths
        cyc(0, 1, 0, 32'h0, 32'h1234_5678, 5'd5, 5'd0, 5'd0, 5'd5);
        cyc(0, 0, 0, 0, 0, 0, 5'd5, 5'd5, 5'd5);
        cyc(0, 1, 1, 32'hDEAD_BEEF, 32'h0, 5'd5, 5'd1, 5'd2, 5'd5);
        cyc(0, 0, 0, 0, 0, 0, 5'd5, 5'd6, 5'd5);

        // Unknown load data must not reach wbData when the ALU path is selected
        cyc(0, 1, 0, xval, 32'hCAFE_0001, 5'd9, 5'd9, 5'd0, 5'd9);
        cyc(0, 0, 0, xval, 32'h0BAD_F00D, 5'd0, 5'd9, 5'd9, 5'd9);

        // x0 write is dropped and not counted
        cyc(0, 1, 0, 32'h0, 32'hFFFF_FFFF, 5'd0, 5'd0, 5'd0, 5'd0);
        cyc(0, 0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0);

        // Same-cycle write/read collision and debug pre-write view
        cyc(0, 1, 0, 32'h0, 32'h11, 5'd7, 5'd0, 5'd0, 5'd0);
        cyc(0, 1, 0, 32'h0, 32'h22, 5'd7, 5'd7, 5'd7, 5'd7);
        cyc(0, 0, 0, 0, 0, 0, 5'd7, 5'd7, 5'd7);
        cyc(0, 0, 0, 0, 0, 0, 5'd7, 5'd7, 5'd7);

        // Reset beats a same-cycle commit
        cyc(0, 1, 0, 32'h0, 32'h55, 5'd3, 5'd0, 5'd0, 5'd0);
        cyc(1, 1, 0, 32'h0, 32'hAA, 5'd3, 5'd3, 5'd3, 5'd3);
        cyc(0, 0, 0, 0, 0, 0, 5'd3, 5'd3, 5'd3);

        // 4-bit counter wrap: 16 commits return it to zero
        for (int i = 0; i < 17; i++) begin
            cyc(0, 1, i[0], $urandom, $urandom, 5'(1 + i % 31), 5'(i), 5'(i + 1), 5'(i));
        end

        // Random traffic with biased address collisions
        for (int i = 0; i < 400; i++) begin
            rd = 5'($urandom_range(0, 31));
            a1 = ($urandom_range(0, 3) == 0) ? rd : 5'($urandom_range(0, 31));
            a2 = ($urandom_range(0, 3) == 0) ? a1 : 5'($urandom_range(0, 31));
            ad = ($urandom_range(0, 3) == 0) ? rd : 5'($urandom_range(0, 31));
            cyc(($urandom_range(0, 63) == 0), 1'($urandom), 1'($urandom),
                $urandom, $urandom, rd, a1, a2, ad);
        end

        // Reset after random writes: every register reads zero on every port
        cyc(1, 1, 0, 32'h0, 32'h1, 5'd4, 5'd0, 5'd0, 5'd0);
        for (int i = 0; i < 32; i++) begin
            cyc(0, 0, 0, 0, 0, 0, 5'(i), 5'(31 - i), 5'(i));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
